// File: rtl/matrix_scan.sv
// Row-at-a-time scanner for a 16x16 LED matrix driven by row/column shift registers.
// Optional MATRIX_BRIGHTNESS_EN adds a 2-bit brightness input that trims OEB within DISPLAY.
module matrix_scan #(
  parameter int CLKDIV           = 1,
  parameter int SCREENTIMERWIDTH = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
`ifdef MATRIX_BRIGHTNESS_EN
  input  logic [1:0]  brightness,
`endif
  input  logic [15:0] fb_data,
  output logic [3:0]  fb_addr,
  output logic        fb_rd,
  output logic        RCLK,
  output logic        RSDI,
  output logic        CSDI,
  output logic        CCLK,
  output logic        LE,
  output logic        OEB,
  output logic        frame_done,
  output logic        busy
);

  localparam int              TW       = SCREENTIMERWIDTH;
  localparam logic [3:0]      DIV_LAST = 4'(CLKDIV - 1);
  localparam logic [TW-1:0]   TMR_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic            fcnt_q, fcnt_d;
  logic [3:0]      div_q, div_d;
  logic            phase_q, phase_d;
  logic [3:0]      slot_q, slot_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            frame_d;
  logic            lit_d;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [1:0]      bright_q, bright_d;
  logic [TW:0]     lim_d;
`endif

  logic [3:0]      fb_addr_d;
  logic            fb_rd_d, rclk_d, rsdi_d, csdi_d, cclk_d, le_d, oeb_d, busy_d;
  logic            in_shift_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    div_d   = div_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    tmr_d   = tmr_q;
    frame_d = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
    bright_d = bright_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FETCH;
          fcnt_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (!fcnt_q) begin
          fcnt_d = 1'b1;
        end else begin
          shreg_d = fb_data;
          state_d = S_SHIFT;
          div_d   = 4'd0;
          phase_d = 1'b0;
          slot_d  = 4'd0;
        end
      end
      S_SHIFT: begin
        // Each bit slot is CLKDIV cycles low then CLKDIV cycles high.
        if (div_q == DIV_LAST) begin
          div_d = 4'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (slot_q == 4'd15) begin
              state_d = S_LATCH;
            end else begin
              slot_d  = slot_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      S_LATCH: begin
        if (div_q == DIV_LAST) begin
          state_d = S_DISPLAY;
          div_d   = 4'd0;
          tmr_d   = '0;
`ifdef MATRIX_BRIGHTNESS_EN
          bright_d = brightness;
`endif
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      S_DISPLAY: begin
        // Row advances even when stopping, so a later restart resumes on the next row.
        if (&tmr_q) begin
          row_d   = row_q + 4'd1;
          frame_d = (row_q == 4'd15);
          fcnt_d  = 1'b0;
          state_d = enable ? S_FETCH : S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
`ifdef MATRIX_BRIGHTNESS_EN
    lim_d = ({{(TW-1){1'b0}}, bright_d} + {{TW{1'b0}}, 1'b1}) << (TW - 2);
    lit_d = ({1'b0, tmr_d} < lim_d);
`else
    lit_d = 1'b1;
`endif
    in_shift_d = (state_d == S_SHIFT);
    fb_rd_d    = (state_d == S_FETCH) && !fcnt_d;
    fb_addr_d  = (state_d == S_FETCH) ? row_d : 4'd0;
    cclk_d     = in_shift_d && phase_d;
    csdi_d     = in_shift_d && shreg_d[15];
    rclk_d     = in_shift_d && (slot_d == 4'd0) && phase_d;
    rsdi_d     = in_shift_d && (slot_d == 4'd0) && (row_d == 4'd0);
    le_d       = (state_d == S_LATCH);
    oeb_d      = !((state_d == S_DISPLAY) && lit_d);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= 4'd0;
      fcnt_q     <= 1'b0;
      div_q      <= 4'd0;
      phase_q    <= 1'b0;
      slot_q     <= 4'd0;
      tmr_q      <= '0;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q   <= 2'd0;
`endif
      fb_addr    <= 4'd0;
      fb_rd      <= 1'b0;
      RCLK       <= 1'b0;
      RSDI       <= 1'b0;
      CSDI       <= 1'b0;
      CCLK       <= 1'b0;
      LE         <= 1'b0;
      OEB        <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      fcnt_q     <= fcnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      tmr_q      <= tmr_d;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
      fb_addr    <= fb_addr_d;
      fb_rd      <= fb_rd_d;
      RCLK       <= rclk_d;
      RSDI       <= rsdi_d;
      CSDI       <= csdi_d;
      CCLK       <= cclk_d;
      LE         <= le_d;
      OEB        <= oeb_d;
      frame_done <= frame_d;
      busy       <= busy_d;
    end
  end

  // Pixel data needs no reset; it is always reloaded in FETCH before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule
